// File: rtl/axi_sparse_mv_ctrl_pkg.sv
// Shared definitions for the sparse MV controller: register offsets, bit positions,
// AXI response codes and the sequencer state type.
package axi_sparse_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CYCLES = 8'h08;
  localparam logic [7:0] OFF_INFO   = 8'h0C;
  localparam logic [7:0] OFF_X_BASE = 8'h10;

  // Word indices (byte offset >> 2); Y[i] follows X[N_LANES-1] directly.
  localparam int REG_CTRL_IDX   = int'(OFF_CTRL >> 2);
  localparam int REG_STATUS_IDX = int'(OFF_STATUS >> 2);
  localparam int REG_CYCLES_IDX = int'(OFF_CYCLES >> 2);
  localparam int REG_INFO_IDX   = int'(OFF_INFO >> 2);
  localparam int REG_X_IDX      = int'(OFF_X_BASE >> 2);

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_TIMEOUT_BIT = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/axi_sparse_mv_ctrl_if.sv
// AXI4-Lite bundle between the PS master and the sparse MV controller.
// Every channel transfers on a cycle where valid and ready are both high; a source holds
// valid and its payload stable until that cycle, and never waits for ready before raising valid.
interface axi_sparse_mv_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_sparse_mv_ctrl_axi_lite_slave_if.sv
// AXI4-Lite handshake engine: latches AW/W independently, issues one commit strobe per write
// and one lookup strobe per read, and registers the B/R responses.
module axi_lite_slave_if
  import axi_sparse_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                aclk,
  input  logic                areset,
  axi_sparse_mv_ctrl_if.slave s_axi,
  output logic                o_wr_en,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [DATA_W-1:0]   o_wr_data,
  output logic [DATA_W/8-1:0] o_wr_strb,
  input  logic                i_wr_err,
  output logic                o_rd_en,
  output logic [ADDR_W-1:0]   o_rd_addr,
  input  logic [DATA_W-1:0]   i_rd_data,
  input  logic                i_rd_err
);

  logic                r_awready, r_aw_held, r_wready, r_w_held, r_bvalid;
  logic                r_arready, r_rvalid;
  logic [ADDR_W-1:0]   r_aw_addr;
  logic [DATA_W-1:0]   r_w_data, r_rdata;
  logic [DATA_W/8-1:0] r_w_strb;
  logic [1:0]          r_bresp, r_rresp;
  logic                w_aw_hs, w_w_hs, w_ar_hs, w_commit;

  assign w_aw_hs  = s_axi.awvalid & r_awready;
  assign w_w_hs   = s_axi.wvalid & r_wready;
  assign w_ar_hs  = s_axi.arvalid & r_arready;
  assign w_commit = r_aw_held & r_w_held;

  assign o_wr_en   = w_commit;
  assign o_wr_addr = r_aw_addr;
  assign o_wr_data = r_w_data;
  assign o_wr_strb = r_w_strb;
  assign o_rd_en   = w_ar_hs;
  assign o_rd_addr = s_axi.araddr;

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_awready <= 1'b0;
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_wready  <= 1'b0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      // Readies re-open only once nothing is held and no response is pending.
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= s_axi.awaddr;
        r_awready <= 1'b0;
      end else if (!r_aw_held && !r_bvalid) begin
        r_awready <= 1'b1;
      end

      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= s_axi.wdata;
        r_w_strb <= s_axi.wstrb;
        r_wready <= 1'b0;
      end else if (!r_w_held && !r_bvalid) begin
        r_wready <= 1'b1;
      end

      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= i_wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_bvalid && s_axi.bready) begin
        r_bvalid <= 1'b0;
      end

      if (w_ar_hs) begin
        r_arready <= 1'b0;
        r_rvalid  <= 1'b1;
        r_rdata   <= i_rd_data;
        r_rresp   <= i_rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_rvalid) begin
        if (s_axi.rready) r_rvalid <= 1'b0;
      end else begin
        r_arready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_sparse_mv_ctrl.sv
// Register file and run sequencer for one sparse MV core: holds X/Y vectors, issues the start
// pulse, measures latency, captures results or times out, and drives a level interrupt.
module axi_sparse_mv_ctrl
  import axi_sparse_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int N_LANES        = 4,
  parameter int X_WIDTH        = 8,
  parameter int Y_WIDTH        = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       aclk,
  input  logic                       areset,
  axi_sparse_mv_ctrl_if.slave        s_axi,
  output logic                       core_start,
  output logic [N_LANES*X_WIDTH-1:0] core_x,
  input  logic                       core_done,
  input  logic [N_LANES*Y_WIDTH-1:0] core_y,
  output logic                       irq,
  output state_t                     dbg_state
);

  localparam int IDX_W = AXI_ADDR_WIDTH - 2;

  if (AXI_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("AXI_DATA_WIDTH must be 32");
  end
  if ((16 + 8 * N_LANES) > (1 << AXI_ADDR_WIDTH)) begin : g_bad_addr_width
    $error("AXI_ADDR_WIDTH too small for the register map");
  end
  if (N_LANES < 1 || N_LANES > 16 || X_WIDTH < 3 || X_WIDTH > 32 || Y_WIDTH < 1 || Y_WIDTH > 32)
  begin : g_bad_lane_params
    $error("lane parameters out of range");
  end

  logic                          w_wr_en, w_wr_err, w_rd_en, w_rd_err, w_busy, w_start_req;
  logic [AXI_ADDR_WIDTH-1:0]     w_wr_addr, w_rd_addr;
  logic [AXI_DATA_WIDTH-1:0]     w_wr_data, w_rd_data;
  logic [AXI_DATA_WIDTH/8-1:0]   w_wr_strb;
  logic [IDX_W-1:0]              w_wr_idx, w_rd_idx;
  logic [X_WIDTH-1:0]            w_xmask;
  logic                          w_unused;

  state_t                        r_state;
  logic                          r_core_start, r_irq_en, r_done, r_timeout;
  logic [31:0]                   r_cycles;
  logic signed [X_WIDTH-1:0]     r_x [N_LANES];
  logic signed [Y_WIDTH-1:0]     r_y [N_LANES];

  axi_lite_slave_if #(.ADDR_W(AXI_ADDR_WIDTH), .DATA_W(AXI_DATA_WIDTH)) u_axi (
    .aclk      (aclk),
    .areset    (areset),
    .s_axi     (s_axi),
    .o_wr_en   (w_wr_en),
    .o_wr_addr (w_wr_addr),
    .o_wr_data (w_wr_data),
    .o_wr_strb (w_wr_strb),
    .i_wr_err  (w_wr_err),
    .o_rd_en   (w_rd_en),
    .o_rd_addr (w_rd_addr),
    .i_rd_data (w_rd_data),
    .i_rd_err  (w_rd_err)
  );

  assign w_wr_idx    = w_wr_addr[AXI_ADDR_WIDTH-1:2];
  assign w_rd_idx    = w_rd_addr[AXI_ADDR_WIDTH-1:2];
  assign w_busy      = (r_state == ST_RUN);
  assign w_start_req = w_wr_en && !w_busy && (w_wr_idx == IDX_W'(REG_CTRL_IDX)) &&
                       w_wr_strb[0] && w_wr_data[CTRL_START_BIT];
  assign w_unused    = ^{w_rd_en, w_wr_data, w_wr_strb, w_wr_addr[1:0], w_rd_addr[1:0]};

  assign core_start = r_core_start;
  assign irq        = r_irq_en & (r_done | r_timeout);
  assign dbg_state  = r_state;

  always_comb begin
    core_x = '0;
    for (int i = 0; i < N_LANES; i++) core_x[i*X_WIDTH +: X_WIDTH] = r_x[i];
  end

  always_comb begin
    w_xmask = '0;
    for (int b = 0; b < X_WIDTH; b++) w_xmask[b] = w_wr_strb[b / 8];
  end

  // A write to STATUS is always legal (W1C); only START and X[i] are blocked during a run.
  always_comb begin
    w_wr_err = 1'b1;
    if (w_wr_idx == IDX_W'(REG_CTRL_IDX))
      w_wr_err = w_busy & w_wr_strb[0] & w_wr_data[CTRL_START_BIT];
    else if (w_wr_idx == IDX_W'(REG_STATUS_IDX))
      w_wr_err = 1'b0;
    for (int i = 0; i < N_LANES; i++)
      if (w_wr_idx == IDX_W'(REG_X_IDX + i)) w_wr_err = w_busy;
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    if (w_rd_idx == IDX_W'(REG_CTRL_IDX)) begin
      w_rd_data[CTRL_IRQ_EN_BIT] = r_irq_en;
    end else if (w_rd_idx == IDX_W'(REG_STATUS_IDX)) begin
      w_rd_data[STAT_BUSY_BIT]    = w_busy;
      w_rd_data[STAT_DONE_BIT]    = r_done;
      w_rd_data[STAT_TIMEOUT_BIT] = r_timeout;
    end else if (w_rd_idx == IDX_W'(REG_CYCLES_IDX)) begin
      w_rd_data = r_cycles;
    end else if (w_rd_idx == IDX_W'(REG_INFO_IDX)) begin
      w_rd_data = {8'(X_WIDTH), 8'(Y_WIDTH), 16'(N_LANES)};
    end else begin
      w_rd_err = 1'b1;
      for (int i = 0; i < N_LANES; i++) begin
        if (w_rd_idx == IDX_W'(REG_X_IDX + i)) begin
          w_rd_data = AXI_DATA_WIDTH'(r_x[i]);
          w_rd_err  = 1'b0;
        end
        if (w_rd_idx == IDX_W'(REG_X_IDX + N_LANES + i)) begin
          w_rd_data = AXI_DATA_WIDTH'(r_y[i]);
          w_rd_err  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= ST_IDLE;
      r_core_start <= 1'b0;
      r_irq_en     <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_cycles     <= '0;
      for (int i = 0; i < N_LANES; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      r_core_start <= 1'b0;
      if (w_wr_en && !w_wr_err) begin
        if (w_wr_idx == IDX_W'(REG_CTRL_IDX) && w_wr_strb[0])
          r_irq_en <= w_wr_data[CTRL_IRQ_EN_BIT];
        if (w_wr_idx == IDX_W'(REG_STATUS_IDX) && w_wr_strb[0]) begin
          if (w_wr_data[STAT_DONE_BIT])    r_done    <= 1'b0;
          if (w_wr_data[STAT_TIMEOUT_BIT]) r_timeout <= 1'b0;
        end
        for (int i = 0; i < N_LANES; i++)
          if (w_wr_idx == IDX_W'(REG_X_IDX + i))
            r_x[i] <= (r_x[i] & ~w_xmask) | (w_wr_data[X_WIDTH-1:0] & w_xmask);
      end

      // Sequencer updates come last so a core_done set beats a same-cycle W1C.
      case (r_state)
        ST_IDLE: begin
          if (w_start_req) begin
            r_state      <= ST_RUN;
            r_core_start <= 1'b1;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_cycles     <= '0;
          end
        end
        ST_RUN: begin
          if (r_cycles != '1) r_cycles <= r_cycles + 32'd1;
          if (core_done) begin
            for (int i = 0; i < N_LANES; i++) r_y[i] <= core_y[i*Y_WIDTH +: Y_WIDTH];
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (r_cycles == 32'(TIMEOUT_CYCLES - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
